// File: rtl/noc_pkg.sv
// Shared NoC types and constants used by link injectors and router input buffers.
package noc_pkg;

    localparam int FLIT_W        = 16;
    localparam int NOC_BUF_DEPTH = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    // Counter must represent every value from 0 up to and including max_credits.
    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Generic flit FIFO, no fall-through: a pushed entry is visible at the head one edge later.
// Full/empty come from registered occupancy; push while full and pop while empty are ignored.
module noc_flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [OW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full     = (r_count == OW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_link_tx.sv
// Credit-based flit injector: source flits buffered, forwarded at most 1/cycle while credits remain.
// Push-to-valid_o is two edges; src_ready_o drops only when the local FIFO is full.
module noc_link_tx
    import noc_pkg::*;
#(
    parameter int  DATA_W      = FLIT_W,
    parameter int  FIFO_DEPTH  = 4,
    parameter int  MAX_CREDITS = NOC_BUF_DEPTH,
    localparam int CW          = credit_width(MAX_CREDITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              src_ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              credit_i,
    output logic [CW-1:0]     credits_o,
    output logic              credit_err_o
);

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_head_dat;
    logic              w_push;
    logic              w_send;
    logic [CW-1:0]     w_credits_nxt;
    logic              w_credit_ovf;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CW-1:0]     r_credits;
    logic              r_credit_err;

    assign src_ready_o = ~w_fifo_full;
    assign w_push      = src_valid_i & src_ready_o;
    assign w_send      = ~w_fifo_empty & (r_credits != '0);

    noc_flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (src_data_i),
        .i_pop      (w_send),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head_dat (w_head_dat)
    );

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        w_credits_nxt = r_credits;
        w_credit_ovf  = 1'b0;
        if (w_send && !credit_i) begin
            w_credits_nxt = r_credits - CW'(1);
        end else if (credit_i && !w_send) begin
            if (r_credits == CW'(MAX_CREDITS)) begin
                w_credit_ovf = 1'b1;
            end else begin
                w_credits_nxt = r_credits + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_credits    <= CW'(MAX_CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            r_valid   <= w_send;
            r_credits <= w_credits_nxt;
            if (w_send) begin
                r_data <= w_head_dat;
            end
            if (w_credit_ovf) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign credits_o    = r_credits;
    assign credit_err_o = r_credit_err;

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx: reset, ordering, credit stall/release, credit cancel, overflow, random traffic.
module tb_noc_link_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid_i;
    logic [15:0] src_data_i;
    logic        src_ready_o;
    logic        valid_o;
    logic [15:0] data_o;
    logic        credit_i;
    logic [2:0]  credits_o;
    logic        credit_err_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] sent_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] rq[$];

    always #5 clk = ~clk;

    noc_link_tx dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid_i  (src_valid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .credits_o    (credits_o),
        .credit_err_o (credit_err_o)
    );

    // Router-side capture of every flit pulse.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            sent_q.push_back(data_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int mism;
        int seq;

        src_valid_i = 1'b0;
        src_data_i  = '0;
        credit_i    = 1'b0;
        rst         = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_credits", credits_o, 4);
        chk("rst_ready", src_ready_o, 1);
        chk("rst_err", credit_err_o, 0);
        repeat (3) tick();
        rst = 1'b0;

        // Credit returned while already full: overflow flag, counter holds.
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        chk("ovf_credits", credits_o, 4);
        chk("ovf_err", credit_err_o, 1);
        repeat (2) tick();
        chk("ovf_err_sticky", credit_err_o, 1);

        // Three back-to-back flits, no credits returned.
        src_valid_i = 1'b1;
        src_data_i  = 16'hA001;
        tick();
        chk("b2b_no_fallthru", valid_o, 0);
        src_data_i = 16'hA002;
        tick();
        chk("b2b_v1", valid_o, 1);
        chk("b2b_d1", data_o, 16'hA001);
        chk("b2b_c1", credits_o, 3);
        src_data_i = 16'hA003;
        tick();
        chk("b2b_v2", valid_o, 1);
        chk("b2b_d2", data_o, 16'hA002);
        chk("b2b_c2", credits_o, 2);
        src_valid_i = 1'b0;
        tick();
        chk("b2b_v3", valid_o, 1);
        chk("b2b_d3", data_o, 16'hA003);
        chk("b2b_c3", credits_o, 1);
        tick();
        chk("b2b_idle_v", valid_o, 0);
        chk("b2b_hold_d", data_o, 16'hA003);
        chk("b2b_hold_c", credits_o, 1);

        credit_i = 1'b1;
        repeat (3) tick();
        credit_i = 1'b0;
        chk("refill_credits", credits_o, 4);

        // Credit exhaustion: eight flits offered, four sent, four left buffered.
        sent_q.delete();
        for (int i = 0; i < 8; i++) begin
            src_valid_i = 1'b1;
            src_data_i  = 16'hB001 + 16'(i);
            tick();
        end
        src_valid_i = 1'b0;
        chk("stall_ready", src_ready_o, 0);
        chk("stall_credits", credits_o, 0);
        chk("stall_valid", valid_o, 0);
        repeat (2) tick();
        chk("stall_valid_hold", valid_o, 0);
        chk("stall_sent_cnt", sent_q.size(), 4);
        mism = 0;
        for (int i = 0; i < sent_q.size() && i < 4; i++) begin
            if (sent_q[i] !== 16'hB001 + 16'(i)) mism++;
        end
        chk("stall_order", mism, 0);
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        chk("release_credit_in", credits_o, 1);
        chk("release_no_send_yet", valid_o, 0);
        tick();
        chk("release_v", valid_o, 1);
        chk("release_d", data_o, 16'hB005);
        chk("release_c", credits_o, 0);
        chk("release_ready", src_ready_o, 1);

        // Asynchronous reset while flits are buffered and valid_o is high.
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_credits", credits_o, 4);
        chk("arst_ready", src_ready_o, 1);
        chk("arst_err_clr", credit_err_o, 0);
        repeat (3) tick();
        rst = 1'b0;
        sent_q.delete();
        repeat (4) tick();
        chk("arst_discard", sent_q.size(), 0);

        // Send and credit return in the same cycle at credits=2.
        src_valid_i = 1'b1;
        src_data_i  = 16'hC001;
        tick();
        src_data_i = 16'hC002;
        tick();
        src_valid_i = 1'b0;
        tick();
        chk("cancel_pre_c", credits_o, 2);
        chk("cancel_pre_d", data_o, 16'hC002);
        src_valid_i = 1'b1;
        src_data_i  = 16'hC003;
        tick();
        src_valid_i = 1'b0;
        credit_i    = 1'b1;
        tick();
        credit_i = 1'b0;
        chk("cancel_c", credits_o, 2);
        chk("cancel_v", valid_o, 1);
        chk("cancel_d", data_o, 16'hC003);

        // Random traffic against a depth-4 router buffer model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        viol = 0;
        seq  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            src_valid_i = (cyc < 300) && ($urandom_range(0, 99) < 60);
            src_data_i  = 16'hD000 + 16'(seq);
            if (src_valid_i && src_ready_o) begin
                exp_q.push_back(src_data_i);
                seq++;
            end
            if (rq.size() > 0 && (cyc >= 300 || $urandom_range(0, 99) < 45)) begin
                void'(rq.pop_front());
                credit_i = 1'b1;
            end else begin
                credit_i = 1'b0;
            end
            tick();
            if (valid_o === 1'b1) begin
                rq.push_back(data_o);
                got_q.push_back(data_o);
            end
            if (rq.size() > 4 || (int'(credits_o) + rq.size()) != 4) viol++;
        end
        src_valid_i = 1'b0;
        credit_i    = 1'b0;
        chk("rand_credit_invariant", viol, 0);
        chk("rand_count", got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
        end
        chk("rand_order", mism, 0);
        chk("rand_final_credits", credits_o, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
